cluster_ce: RTL and testbench

CLUSTER_CE -- requirements
Module: cluster_ce

---
 rtl/cluster_ce_pkg.sv | 55 +++++
 rtl/cluster_ce_sort3.sv | 83 ++++++++
 rtl/cluster_ce.sv | 137 +++++++++++++
 tb/tb_cluster_ce.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cluster_ce_pkg.sv
// +----------------------------------------------------------------------+
// | cluster_ce_pkg : shared constants, enums and helpers for cluster_ce   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package cluster_ce_pkg;

   localparam int DIM      = 3;
   localparam int DIM_W    = 8;
   localparam int CENTER_W = 24;
   localparam int AXIS_W   = 2;
   localparam int DIST_W   = 18;
   localparam int SQ_W     = 2 * DIM_W;

   typedef enum logic [AXIS_W-1:0] {
      AXIS_X     = 2'd0,
      AXIS_Y     = 2'd1,
      AXIS_Z     = 2'd2,
      AXIS_X_ALT = 2'd3
   } axis_e;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'd0,
      MODE_SORT  = 2'd1,
      MODE_POINT = 2'd2
   } mode_e;

   // Dimension 0 is x, stored in the most significant byte.
   function automatic logic [DIM_W-1:0] center_dim(input logic [CENTER_W-1:0] c,
                                                   input int unsigned d);
      return c[(DIM-1-d)*DIM_W +: DIM_W];
   endfunction

   function automatic logic [DIM_W-1:0] center_key(input logic [CENTER_W-1:0] c,
                                                   input axis_e a);
      logic [DIM_W-1:0] k;
      case (a)
         AXIS_Y:  k = c[15:8];
         AXIS_Z:  k = c[7:0];
         default: k = c[23:16];
      endcase
      return k;
   endfunction

   function automatic logic [SQ_W-1:0] sq_diff(input logic [DIM_W-1:0] a,
                                               input logic [DIM_W-1:0] b);
      logic [SQ_W-1:0] d;
      d = (a > b) ? SQ_W'(a - b) : SQ_W'(b - a);
      return d * d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cluster_ce_sort3.sv
// +----------------------------------------------------------------------+
// | cluster_ce_sort3 : combinational stable 3-way sort with child enables |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cluster_ce_sort3
   import cluster_ce_pkg::*;
(
   input  logic                left_en,
   input  logic                right_en,
   input  logic [AXIS_W-1:0]   axis,
   input  logic [CENTER_W-1:0] left,
   input  logic [CENTER_W-1:0] parent,
   input  logic [CENTER_W-1:0] right,
   output logic [CENTER_W-1:0] new_left,
   output logic [CENTER_W-1:0] new_parent,
   output logic [CENTER_W-1:0] new_right,
   output logic                left_switch,
   output logic                parent_switch,
   output logic                right_switch
);

   logic [DIM_W-1:0] w_key_l;
   logic [DIM_W-1:0] w_key_p;
   logic [DIM_W-1:0] w_key_r;
   logic [1:0]       w_rank_l;
   logic [1:0]       w_rank_p;
   logic [1:0]       w_rank_r;

   assign w_key_l = center_key(left,   axis_e'(axis));
   assign w_key_p = center_key(parent, axis_e'(axis));
   assign w_key_r = center_key(right,  axis_e'(axis));

   // Rank = number of entries ordered before this one; ties favour the lower
   // original position, so the three ranks always form a permutation.
   assign w_rank_l = {1'b0, (w_key_p <  w_key_l)} + {1'b0, (w_key_r <  w_key_l)};
   assign w_rank_p = {1'b0, (w_key_l <= w_key_p)} + {1'b0, (w_key_r <  w_key_p)};
   assign w_rank_r = {1'b0, (w_key_l <= w_key_r)} + {1'b0, (w_key_p <= w_key_r)};

   always_comb begin
      new_left      = left;
      new_parent    = parent;
      new_right     = right;
      left_switch   = 1'b0;
      parent_switch = 1'b0;
      right_switch  = 1'b0;
      if (left_en && right_en) begin
         if (w_rank_l == 2'd0)      new_left = left;
         else if (w_rank_p == 2'd0) new_left = parent;
         else                       new_left = right;

         if (w_rank_l == 2'd1)      new_parent = left;
         else if (w_rank_p == 2'd1) new_parent = parent;
         else                       new_parent = right;

         if (w_rank_l == 2'd2)      new_right = left;
         else if (w_rank_p == 2'd2) new_right = parent;
         else                       new_right = right;

         left_switch   = (w_rank_l != 2'd0);
         parent_switch = (w_rank_p != 2'd1);
         right_switch  = (w_rank_r != 2'd2);
      end else if (left_en) begin
         if (w_key_l > w_key_p) begin
            new_left      = parent;
            new_parent    = left;
            left_switch   = 1'b1;
            parent_switch = 1'b1;
         end
      end else if (right_en) begin
         if (w_key_r < w_key_p) begin
            new_right     = parent;
            new_parent    = right;
            right_switch  = 1'b1;
            parent_switch = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/cluster_ce.sv
// +----------------------------------------------------------------------+
// | cluster_ce : cluster compute element (sort / point propagation)       |
// | Optional: CLUSTER_CE_DEBUG_EN enables a per-edge trace line.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cluster_ce
   import cluster_ce_pkg::*;
#(
   parameter string NAME = "unknown"
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                sorting,
   input  logic                point_prop,
   input  logic                left_en,
   input  logic                right_en,
   input  logic [CENTER_W-1:0] left,
   input  logic [CENTER_W-1:0] parent,
   input  logic [CENTER_W-1:0] right,
   input  logic [AXIS_W-1:0]   axis,
   output logic                stable,
   output logic                send_left,
   output logic                send_right,
   output logic                left_switch,
   output logic                parent_switch,
   output logic                right_switch,
   output logic [CENTER_W-1:0] new_left,
   output logic [CENTER_W-1:0] new_parent,
   output logic [CENTER_W-1:0] new_right
);

   mode_e               w_mode;
   logic [CENTER_W-1:0] w_sort_left;
   logic [CENTER_W-1:0] w_sort_parent;
   logic [CENTER_W-1:0] w_sort_right;
   logic                w_sw_left;
   logic                w_sw_parent;
   logic                w_sw_right;
   logic [DIST_W-1:0]   w_dist_l;
   logic [DIST_W-1:0]   w_dist_r;
   logic                w_send_left;
   logic                w_send_right;

   assign w_mode = sorting    ? MODE_SORT  :
                   point_prop ? MODE_POINT : MODE_IDLE;

   cluster_ce_sort3 u_sort3 (
      .left_en       (left_en),
      .right_en      (right_en),
      .axis          (axis),
      .left          (left),
      .parent        (parent),
      .right         (right),
      .new_left      (w_sort_left),
      .new_parent    (w_sort_parent),
      .new_right     (w_sort_right),
      .left_switch   (w_sw_left),
      .parent_switch (w_sw_parent),
      .right_switch  (w_sw_right)
   );

   always_comb begin
      w_dist_l = '0;
      w_dist_r = '0;
      for (int d = 0; d < DIM; d++) begin
         w_dist_l = w_dist_l + DIST_W'(sq_diff(center_dim(parent, d), center_dim(left,  d)));
         w_dist_r = w_dist_r + DIST_W'(sq_diff(center_dim(parent, d), center_dim(right, d)));
      end
   end

   assign w_send_left  = left_en & (~right_en | (w_dist_l <= w_dist_r));
   assign w_send_right = right_en & ~w_send_left;

   always_ff @(posedge clk) begin
      if (rst) begin
         stable        <= 1'b0;
         send_left     <= 1'b0;
         send_right    <= 1'b0;
         left_switch   <= 1'b0;
         parent_switch <= 1'b0;
         right_switch  <= 1'b0;
         new_left      <= '0;
         new_parent    <= '0;
         new_right     <= '0;
      end else if (en) begin
         case (w_mode)
            MODE_SORT: begin
               new_left      <= w_sort_left;
               new_parent    <= w_sort_parent;
               new_right     <= w_sort_right;
               left_switch   <= w_sw_left;
               parent_switch <= w_sw_parent;
               right_switch  <= w_sw_right;
               stable        <= ~(w_sw_left | w_sw_parent | w_sw_right);
               send_left     <= 1'b0;
               send_right    <= 1'b0;
            end
            MODE_POINT: begin
               new_left      <= left;
               new_parent    <= parent;
               new_right     <= right;
               left_switch   <= 1'b0;
               parent_switch <= 1'b0;
               right_switch  <= 1'b0;
               stable        <= 1'b0;
               send_left     <= w_send_left;
               send_right    <= w_send_right;
            end
            default: begin
               new_left      <= left;
               new_parent    <= parent;
               new_right     <= right;
               left_switch   <= 1'b0;
               parent_switch <= 1'b0;
               right_switch  <= 1'b0;
               stable        <= 1'b0;
               send_left     <= 1'b0;
               send_right    <= 1'b0;
            end
         endcase
      end
   end

`ifdef CLUSTER_CE_DEBUG_EN
   always_ff @(posedge clk) begin
      $display("[%s] mode=%s axis=%0d L=%06h P=%06h R=%06h sw=%b%b%b stable=%b send=%b%b",
               NAME, w_mode.name(), axis, left, parent, right,
               left_switch, parent_switch, right_switch, stable, send_left, send_right);
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cluster_ce.sv
// +----------------------------------------------------------------------+
// | tb_cluster_ce : directed + randomized check of cluster_ce             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_cluster_ce;

   typedef struct packed {
      logic        stable;
      logic        send_left;
      logic        send_right;
      logic        left_switch;
      logic        parent_switch;
      logic        right_switch;
      logic [23:0] new_left;
      logic [23:0] new_parent;
      logic [23:0] new_right;
   } out_t;

   logic        clk = 1'b0;
   logic        rst, en, sorting, point_prop, left_en, right_en;
   logic [23:0] left, parent, right;
   logic [1:0]  axis;
   logic        stable, send_left, send_right;
   logic        left_switch, parent_switch, right_switch;
   logic [23:0] new_left, new_parent, new_right;

   int   n_compared   = 0;
   int   n_mismatched = 0;
   out_t exp_q        = '0;

   always #5 clk = ~clk;

   cluster_ce #(.NAME("tb_ce")) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .sorting       (sorting),
      .point_prop    (point_prop),
      .left_en       (left_en),
      .right_en      (right_en),
      .left          (left),
      .parent        (parent),
      .right         (right),
      .axis          (axis),
      .stable        (stable),
      .send_left     (send_left),
      .send_right    (send_right),
      .left_switch   (left_switch),
      .parent_switch (parent_switch),
      .right_switch  (right_switch),
      .new_left      (new_left),
      .new_parent    (new_parent),
      .new_right     (new_right)
   );

   function automatic int key_of(input logic [23:0] c, input logic [1:0] a);
      int x, y, z;
      x = int'(c) / 65536;
      y = (int'(c) / 256) % 256;
      z = int'(c) % 256;
      if (a == 2'd1) return y;
      if (a == 2'd2) return z;
      return x;
   endfunction

   function automatic int dist2(input logic [23:0] a, input logic [23:0] b);
      int s = 0;
      for (int d = 0; d < 3; d++) begin
         int da = (int'(a) >> (8 * d)) % 256;
         int db = (int'(b) >> (8 * d)) % 256;
         s += (da - db) * (da - db);
      end
      return s;
   endfunction

   // Behavioural model of one enabled evaluation.
   function automatic out_t model(input logic s, pp, le, re, input logic [1:0] a,
                                  input logic [23:0] l, p, r);
      out_t o;
      o = '0;
      o.new_left = l; o.new_parent = p; o.new_right = r;
      if (s) begin
         if (le && re) begin
            logic [23:0] v[3];
            int          k[3];
            int          id[3];
            v[0] = l; v[1] = p; v[2] = r;
            for (int i = 0; i < 3; i++) begin
               k[i] = key_of(v[i], a);
               id[i] = i;
            end
            for (int i = 1; i < 3; i++)
               for (int j = i; j > 0 && k[j-1] > k[j]; j--) begin
                  int tk = k[j]; logic [23:0] tv = v[j]; int ti = id[j];
                  k[j] = k[j-1]; v[j] = v[j-1]; id[j] = id[j-1];
                  k[j-1] = tk; v[j-1] = tv; id[j-1] = ti;
               end
            o.new_left = v[0]; o.new_parent = v[1]; o.new_right = v[2];
            o.left_switch   = (id[0] != 0);
            o.parent_switch = (id[1] != 1);
            o.right_switch  = (id[2] != 2);
         end else if (le) begin
            if (key_of(l, a) > key_of(p, a)) begin
               o.new_left = p; o.new_parent = l;
               o.left_switch = 1'b1; o.parent_switch = 1'b1;
            end
         end else if (re) begin
            if (key_of(r, a) < key_of(p, a)) begin
               o.new_right = p; o.new_parent = r;
               o.right_switch = 1'b1; o.parent_switch = 1'b1;
            end
         end
         o.stable = !(o.left_switch || o.parent_switch || o.right_switch);
      end else if (pp) begin
         o.send_left  = le && (!re || dist2(p, l) <= dist2(p, r));
         o.send_right = re && !o.send_left;
      end
      return o;
   endfunction

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
      n_compared++;
      assert (got === want)
      else begin
         n_mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic step(input string tag, input logic r_i, e_i, s_i, pp_i, le_i, re_i,
                       input logic [1:0] a_i, input logic [23:0] l_i, p_i, rr_i);
      out_t got;
      @(negedge clk);
      rst = r_i; en = e_i; sorting = s_i; point_prop = pp_i;
      left_en = le_i; right_en = re_i; axis = a_i;
      left = l_i; parent = p_i; right = rr_i;
      if (r_i)      exp_q = '0;
      else if (e_i) exp_q = model(s_i, pp_i, le_i, re_i, a_i, l_i, p_i, rr_i);
      @(posedge clk);
      #1;
      got = {stable, send_left, send_right, left_switch, parent_switch, right_switch,
             new_left, new_parent, new_right};
      check(tag, {2'b00, got}, {2'b00, exp_q});
   endtask

   function automatic logic [23:0] rand_center();
      if ($urandom_range(0, 1) == 0)
         return {6'd0, 2'($urandom_range(0, 3)), 6'd0, 2'($urandom_range(0, 3)),
                 6'd0, 2'($urandom_range(0, 3))};
      return 24'($urandom);
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; sorting = 1'b0; point_prop = 1'b0;
      left_en = 1'b0; right_en = 1'b0; axis = 2'd0;
      left = '0; parent = '0; right = '0;

      step("reset",       1, 0, 1, 0, 1, 1, 2'd0, 24'h123456, 24'h654321, 24'hABCDEF);
      step("sort_swap",   0, 1, 1, 0, 1, 1, 2'd0, 24'h500000, 24'h300000, 24'h700000);
      check("swap_const", {2'b00, stable, left_switch, parent_switch, right_switch, new_left, new_parent, new_right},
                          {2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 24'h300000, 24'h500000, 24'h700000});
      step("rst_one",     1, 1, 1, 0, 1, 1, 2'd0, 24'h500000, 24'h300000, 24'h700000);
      step("sorted_z",    0, 1, 1, 0, 1, 1, 2'd2, 24'h000010, 24'h000020, 24'h000030);
      step("partial_y",   0, 1, 1, 0, 1, 0, 2'd1, 24'h004000, 24'h002000, 24'hFFFFFF);
      step("tie_x",       0, 1, 1, 0, 1, 0, 2'd0, 24'h20AA00, 24'h20BB00, 24'h000000);
      step("tie3_x",      0, 1, 1, 0, 1, 1, 2'd3, 24'h20AA00, 24'h20BB00, 24'h20CC00);
      step("sort_none",   0, 1, 1, 0, 0, 0, 2'd1, 24'hFF0000, 24'h00FF00, 24'h0000FF);
      step("sort_right",  0, 1, 1, 0, 0, 1, 2'd2, 24'h111111, 24'h000050, 24'h000040);
      step("point_both",  0, 1, 0, 1, 1, 1, 2'd0, 24'h121212, 24'h101010, 24'h000000);
      check("point_const", {78'd0, send_left, send_right}, {78'd0, 1'b1, 1'b0});
      step("point_right", 0, 1, 0, 1, 0, 1, 2'd0, 24'h121212, 24'h101010, 24'h000000);
      check("point_r_const", {78'd0, send_left, send_right}, {78'd0, 1'b0, 1'b1});
      step("point_none",  0, 1, 0, 1, 0, 0, 2'd0, 24'h121212, 24'h101010, 24'h000000);
      step("prio_sort",   0, 1, 1, 1, 1, 1, 2'd0, 24'h900000, 24'h100000, 24'h500000);
      step("hold_en0",    0, 0, 0, 1, 1, 1, 2'd1, 24'hDEADBE, 24'h0BADF0, 24'h123123);
      step("idle",        0, 1, 0, 0, 1, 1, 2'd1, 24'hDEADBE, 24'h0BADF0, 24'h123123);
      step("rst_mid",     1, 1, 1, 0, 1, 1, 2'd0, 24'h500000, 24'h300000, 24'h100000);
      step("after_rst",   0, 1, 1, 0, 1, 1, 2'd0, 24'h500000, 24'h300000, 24'h100000);

      for (int i = 0; i < 400; i++) begin
         step("random",
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) != 0),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              rand_center(), rand_center(), rand_center());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

`default_nettype wire
